// File: rtl/game_controller_pkg.sv
// Shared constants, state encoding and level helper for the frog-crossing game controller.
package game_controller_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int V_DISPLAY_DEF = 480;

  localparam logic [2:0] LEVEL_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  function automatic logic [2:0] level_inc(input logic [2:0] lvl);
    return (lvl == LEVEL_MAX) ? lvl : lvl + 3'd1;
  endfunction

endpackage

// File: rtl/game_controller_start_sync.sv
// Two-flop synchronizer for the raw start button followed by a rising-edge detector.
module start_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_start_evt
);

  logic [1:0] r_sync;
  logic       r_start_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_start_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_start};
      r_start_d <= r_sync[1];
    end
  end

  assign o_start_evt = r_sync[1] & ~r_start_d;

endmodule

// File: rtl/game_controller.sv
// Game flow controller: frame timing, hit latching, lives/level bookkeeping and car speed.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int LIVES_INIT      = 3,
  parameter int HIT_FRAMES      = 60,
  parameter int WIN_Y           = 32,
  parameter int CAR_PERIOD_BASE = 1000000,
  parameter int CAR_PERIOD_STEP = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        collision,
  input  logic [9:0]  player_y,
  input  logic        start,
  output logic [1:0]  state,
  output logic        move_enable,
  output logic        player_reset,
  output logic        frame_tick,
  output logic [1:0]  lives,
  output logic [2:0]  level,
  output logic [23:0] car_period
);

  generate
    if (CAR_PERIOD_BASE <= 7 * CAR_PERIOD_STEP) begin : g_bad_period
      $error("CAR_PERIOD_BASE must exceed 7*CAR_PERIOD_STEP");
    end
    if (CAR_PERIOD_BASE >= (1 << 24)) begin : g_bad_base
      $error("CAR_PERIOD_BASE must fit in 24 bits");
    end
    if (LIVES_INIT < 1 || LIVES_INIT > 3) begin : g_bad_lives
      $error("LIVES_INIT must be 1..3");
    end
    if (HIT_FRAMES < 1 || HIT_FRAMES > 255) begin : g_bad_hit_frames
      $error("HIT_FRAMES must be 1..255");
    end
  endgenerate

  localparam logic [9:0]  LP_H_DISPLAY  = 10'(H_DISPLAY);
  localparam logic [9:0]  LP_V_DISPLAY  = 10'(V_DISPLAY);
  localparam logic [9:0]  LP_WIN_Y      = 10'(WIN_Y);
  localparam logic [7:0]  LP_HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [1:0]  LP_LIVES_INIT = 2'(LIVES_INIT);
  localparam logic [23:0] LP_BASE       = 24'(CAR_PERIOD_BASE);
  localparam logic [23:0] LP_STEP       = 24'(CAR_PERIOD_STEP);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_lives, w_lives_nxt;
  logic [2:0]  r_level, w_level_nxt;
  logic [7:0]  r_hit_cnt, w_hit_cnt_nxt;
  logic        r_player_reset, w_player_reset_nxt;
  logic        r_frame_tick;
  logic        r_hit_flag;
  logic [23:0] r_car_period;
  logic        w_start_evt;
  logic        w_active_hit;

  start_sync u_start_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .o_start_evt (w_start_evt)
  );

  // Collisions only count inside the visible raster; blanking overlap is noise.
  assign w_active_hit = collision && (h_count < LP_H_DISPLAY) && (v_count < LP_V_DISPLAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
      r_hit_flag   <= 1'b0;
    end else begin
      r_frame_tick <= (h_count == 10'd0) && (v_count == LP_V_DISPLAY);
      r_hit_flag   <= r_frame_tick ? 1'b0 : (r_hit_flag | w_active_hit);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt        = r_state;
    w_lives_nxt        = r_lives;
    w_level_nxt        = r_level;
    w_hit_cnt_nxt      = r_hit_cnt;
    w_player_reset_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_evt) begin
          w_state_nxt        = ST_PLAY;
          w_lives_nxt        = LP_LIVES_INIT;
          w_level_nxt        = 3'd0;
          w_hit_cnt_nxt      = 8'd0;
          w_player_reset_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (r_frame_tick) begin
          // A hit in the same frame as a goal crossing takes priority.
          if (r_hit_flag) begin
            w_lives_nxt   = r_lives - 2'd1;
            w_hit_cnt_nxt = 8'd0;
            w_state_nxt   = (r_lives == 2'd1) ? ST_OVER : ST_HIT;
          end else if (player_y < LP_WIN_Y) begin
            w_level_nxt        = level_inc(r_level);
            w_player_reset_nxt = 1'b1;
          end
        end
      end
      ST_HIT: begin
        if (r_frame_tick) begin
          if (r_hit_cnt == LP_HIT_LAST) begin
            w_state_nxt        = ST_PLAY;
            w_hit_cnt_nxt      = 8'd0;
            w_player_reset_nxt = 1'b1;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_lives        <= LP_LIVES_INIT;
      r_level        <= 3'd0;
      r_hit_cnt      <= 8'd0;
      r_player_reset <= 1'b0;
      r_car_period   <= LP_BASE;
    end else begin
      r_state        <= w_state_nxt;
      r_lives        <= w_lives_nxt;
      r_level        <= w_level_nxt;
      r_hit_cnt      <= w_hit_cnt_nxt;
      r_player_reset <= w_player_reset_nxt;
      r_car_period   <= LP_BASE - (LP_STEP * {21'd0, r_level});
    end
  end

  assign state        = r_state;
  assign move_enable  = (r_state == ST_PLAY);
  assign player_reset = r_player_reset;
  assign frame_tick   = r_frame_tick;
  assign lives        = r_lives;
  assign level        = r_level;
  assign car_period   = r_car_period;

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-003 Parameter LIVES_INIT, 3, lives at game start (1..3).
REQ-004 Parameter HIT_FRAMES, 60, frames frozen after a hit (1..255).
REQ-005 Parameter WIN_Y, 32, player_y strictly below this is a goal crossing.
REQ-006 Parameter CAR_PERIOD_BASE, 1000000, car step period at level 0 in clocks.
REQ-007 Parameter CAR_PERIOD_STEP, 100000, period reduction per level; BASE > 7*STEP, checked at elaboration.
REQ-008 CLK  in  1  system clock, all logic on rising edge.
REQ-009 RST_N  in  1  reset, asynchronous, active-low.
REQ-010 h_count  in  10  VGA horizontal counter.
REQ-011 v_count  in  10  VGA vertical counter.
REQ-012 collision  in  1  player/car pixel overlap for current pixel.
REQ-013 player_y  in  10  player top edge.
REQ-014 start  in  1  raw button level (any SW), asynchronous.
REQ-015 state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-016 move_enable  out  1  cars and player may move.
REQ-017 player_reset  out  1  one-cycle pulse: return frog to start position.
REQ-018 frame_tick  out  1  one-cycle pulse at start of vertical blank.
REQ-019 lives  out  2  remaining lives.
REQ-020 level  out  3  current level 0..7.
REQ-021 car_period  out  24  car step period for car movement counters.

Function
REQ-022 frame_tick SHALL be 1 for the single cycle after h_count==0 and v_count==V_DISPLAY are sampled together.
REQ-023 hit_flag SHALL set on any cycle with collision=1, h_count<H_DISPLAY, v_count<V_DISPLAY; ignored outside active video.
REQ-024 hit_flag SHALL clear on the frame_tick cycle; a collision on that same cycle cannot occur (blanking).
REQ-025 start SHALL pass a 2-flop synchronizer then rising-edge detect; held level yields exactly one start event.
REQ-026 IDLE: move_enable=0; start event -> PLAY, lives=LIVES_INIT, level=0, player_reset pulse next cycle.
REQ-027 PLAY: move_enable=1; decisions made only on frame_tick cycle.
REQ-028 PLAY, frame_tick, hit_flag=1: lives decrements; if lives was 1 -> OVER (lives=0), else -> HIT.
REQ-029 PLAY, frame_tick, hit_flag=0, player_y<WIN_Y: level increments, saturating at 7; player_reset pulse; stay PLAY.
REQ-030 Hit and win in the same frame: hit wins, level unchanged.
REQ-031 HIT: move_enable=0; frame counter counts frame_ticks; on HIT_FRAMES-th tick -> PLAY with player_reset pulse, counter cleared.
REQ-032 OVER: move_enable=0, lives=0, level held; start event behaves as REQ-026.
REQ-033 start events in PLAY and HIT SHALL be ignored.
REQ-034 car_period SHALL equal CAR_PERIOD_BASE - level*CAR_PERIOD_STEP, registered, valid one cycle after level changes.
REQ-035 All state/lives/level updates SHALL appear at outputs one cycle after the deciding frame_tick cycle.
REQ-036 player_reset SHALL never exceed one cycle high.

Reset
REQ-037 RST_N low SHALL immediately force: state=IDLE, move_enable=0, player_reset=0, frame_tick=0, lives=LIVES_INIT, level=0, car_period=CAR_PERIOD_BASE, hit_flag=0, frame counter=0, synchronizer=0.
REQ-038 Reset mid-HIT or mid-frame SHALL discard pending hit and counter; first start event after release starts a new game.

Structure
REQ-039 H_DISPLAY, V_DISPLAY and state encodings SHALL live in the shared constant.v package.
REQ-040 Synchronizer plus edge detect SHALL be sub-module start_sync.

Verification
REQ-041 Reset, pulse start -> state 0->1, player_reset one cycle, lives=3, level=0, car_period=1000000.
REQ-042 PLAY, collision at (100,330) -> at next frame_tick lives 3->2, state=HIT, move_enable=0; 60 ticks later state=PLAY with player_reset.
REQ-043 Three hit frames (with recovery) -> lives 0, state=OVER; start held high -> exactly one restart.
REQ-044 player_y=20 for 9 frames -> level saturates at 7, car_period=300000, 9 player_reset pulses.
REQ-045 Collision and player_y=20 same frame -> lives decrement, level unchanged; collision during v_count=490 ignored.
REQ-046 RST_N low during HIT frame 30 -> all REQ-037 values asynchronously, state IDLE.
